// File: rtl/debounce_pkg.sv
// ----------------------------------------------------------------------------
// debounce_pkg
//   Shared definitions for the button debouncer and related input
//   conditioning stages.
//
//   Contents:
//     db_state_e           - 2-bit FSM state encoding
//     DEF_STABLE_CYCLES    - default number of agreeing samples to accept
//     DEF_CNT_W            - default stability counter width
//     db_target_level()    - level that a given state holds or is checking for
// ----------------------------------------------------------------------------
package debounce_pkg;

    localparam int DEF_STABLE_CYCLES = 16;
    localparam int DEF_CNT_W         = 5;

    typedef enum logic [1:0] {
        IDLE_LOW   = 2'd0,
        CHECK_HIGH = 2'd1,
        IDLE_HIGH  = 2'd2,
        CHECK_LOW  = 2'd3
    } db_state_e;

    // Level the FSM is either resting at (IDLE_*) or heading towards (CHECK_*).
    function automatic logic db_target_level(input db_state_e st);
        return (st == CHECK_HIGH) || (st == IDLE_HIGH);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer for a single asynchronous bit. Reusable by any
//   stage that samples an input not generated in the clk domain.
//
//   Ports:
//     clk    in   sampling clock
//     reset  in   asynchronous active-low reset (both flops clear to 0)
//     d      in   asynchronous input
//     q      out  synchronized output (second flop)
// ----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    // First flop may go metastable; only the second one is consumed.
    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// ----------------------------------------------------------------------------
// button_debouncer
//   Turns a bouncing switch/button input into a clean level plus one-cycle
//   rise/fall pulses. A change of level is accepted only after STABLE_CYCLES
//   consecutive samples agree on the new value; any disagreeing sample
//   abandons the pending change.
//
//   Parameters:
//     STABLE_CYCLES  agreeing samples needed to accept a change (2 .. 2^CNT_W-1)
//     CNT_W          stability counter width (2^CNT_W > STABLE_CYCLES)
//
//   Ports:
//     clk         in   single clock, rising edge
//     reset       in   asynchronous active-low reset
//     btn_in      in   raw input
//     level       out  debounced level (registered)
//     rise_pulse  out  one-cycle pulse on level 0->1 (registered)
//     fall_pulse  out  one-cycle pulse on level 1->0 (registered)
//
//   Build option:
//     DEBOUNCE_SYNC_EN  when defined, btn_in passes through a 2-flop
//                       synchronizer first (adds 2 cycles of latency).
//                       When undefined, btn_in must already be synchronous
//                       to clk.
// ----------------------------------------------------------------------------
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic level,
    output logic rise_pulse,
    output logic fall_pulse
);

    // Count value at which the STABLE_CYCLES-th agreeing sample commits.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------
    // Sampled input
    // ------------------------------------------------------------------
    logic s;

`ifdef DEBOUNCE_SYNC_EN
    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (s)
    );
`else
    assign s = btn_in;
`endif

    // ------------------------------------------------------------------
    // Debounce FSM
    //   cnt holds the number of agreeing samples seen so far while in a
    //   CHECK_* state; the sample that moves IDLE_* -> CHECK_* is the
    //   first, so entry loads 1. It saturates at CNT_LAST by construction
    //   (that value always leaves the CHECK_* state), so it never wraps.
    // ------------------------------------------------------------------
    db_state_e        state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE_LOW;
            cnt        <= '0;
            level      <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            // Pulses are single-cycle: cleared unless set below.
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;

            case (state)
                IDLE_LOW: begin
                    if (s) begin
                        state <= CHECK_HIGH;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt   <= '0;
                    end
                end

                CHECK_HIGH: begin
                    if (!s) begin
                        // Bounce: drop the pending rise without touching level.
                        state <= IDLE_LOW;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state      <= IDLE_HIGH;
                        level      <= 1'b1;
                        rise_pulse <= 1'b1;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                IDLE_HIGH: begin
                    if (!s) begin
                        state <= CHECK_LOW;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt   <= '0;
                    end
                end

                CHECK_LOW: begin
                    if (s) begin
                        state <= IDLE_HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state      <= IDLE_LOW;
                        level      <= 1'b0;
                        fall_pulse <= 1'b1;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                default: begin
                    // Unreachable with a 2-bit encoding; recover to the
                    // state that matches the current level.
                    state <= level ? IDLE_HIGH : IDLE_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Debug visibility: level the FSM is currently aiming for.
    logic target;
    assign target = db_target_level(state);

    // A committed level always agrees with the resting state's target.
    // (Kept as a named signal for waveform debug; no logic consumes it.)
    logic unused_target;
    assign unused_target = target;

endmodule

// File: tb/tb_button_debouncer.sv
// Randomized bench with a reference model: the debounced level flips when
// the last N sampled inputs (since reset) all differ from the current level.
module tb_button_debouncer;

    localparam int N = 4;
`ifdef DEBOUNCE_SYNC_EN
    localparam int LAT = N + 2;
`else
    localparam int LAT = N;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic btn_in = 1'b0;
    logic level, rise_pulse, fall_pulse;

    always #5 clk = ~clk;

    button_debouncer #(.STABLE_CYCLES(N), .CNT_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_in     (btn_in),
        .level      (level),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    int checks = 0;
    int failures = 0;

    // reference model state
    bit m_level, m_rise, m_fall;
    bit hist[$];
    bit m_q1, m_q2;
    bit prev_pulse;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_level = 0; m_rise = 0; m_fall = 0;
        hist.delete();
        m_q1 = 0; m_q2 = 0;
        prev_pulse = 0;
    endfunction

    function automatic void model_edge(input bit b);
        bit s;
        bit all_diff;
`ifdef DEBOUNCE_SYNC_EN
        s = m_q2; m_q2 = m_q1; m_q1 = b;
`else
        s = b;
`endif
        m_rise = 0; m_fall = 0;
        hist.push_back(s);
        if (hist.size() > N) void'(hist.pop_front());
        if (hist.size() == N) begin
            all_diff = 1;
            foreach (hist[i]) if (hist[i] == m_level) all_diff = 0;
            if (all_diff) begin
                m_level = !m_level;
                if (m_level) m_rise = 1; else m_fall = 1;
            end
        end
    endfunction

    task automatic cmp_outputs(input string tag);
        chk({tag, "_level"}, level, m_level);
        chk({tag, "_rise"}, rise_pulse, m_rise);
        chk({tag, "_fall"}, fall_pulse, m_fall);
        chk({tag, "_excl"}, rise_pulse & fall_pulse, 0);
        chk({tag, "_consec"}, prev_pulse & (rise_pulse | fall_pulse), 0);
        prev_pulse = rise_pulse | fall_pulse;
    endtask

    // drive one sample, clock it, compare #1 after the edge
    task automatic step(input bit b, input string tag);
        btn_in = b;
        @(posedge clk);
        if (reset) model_edge(b);
        #1;
        cmp_outputs(tag);
    endtask

    // hold btn_in=b and count edges until the expected pulse appears
    task automatic measure(input string tag, input bit b, input int exp);
        int n;
        bit seen;
        n = 0; seen = 0;
        while (!seen && n < 50) begin
            step(b, tag);
            n++;
            seen = b ? rise_pulse : fall_pulse;
        end
        chk({tag, "_latency"}, n, exp);
        step(b, {tag, "_after"});
        chk({tag, "_pulse_gone"}, b ? rise_pulse : fall_pulse, 0);
        chk({tag, "_level_held"}, level, b);
    endtask

    task automatic assert_reset(input string tag);
        #1 reset = 1'b0;
        model_reset();
        #1;
        cmp_outputs(tag);
        chk({tag, "_state"}, dut.state, 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        cmp_outputs("rst0");

        // reset held while input toggles
        for (int i = 0; i < 8; i++) step(1'($urandom), "rst_hold");
        chk("rst_hold_state", dut.state, 0);
        step(0, "rst_hold");
        release_reset();
        for (int i = 0; i < 3; i++) step(0, "flush");

        // clean rise and fall
        measure("rise", 1, LAT);
        for (int i = 0; i < 2; i++) step(1, "hold_hi");
        measure("fall", 0, LAT);
        for (int i = 0; i < 3; i++) step(0, "hold_lo");

        // short glitch rejected, then a real rise
        step(1, "glitch"); step(1, "glitch"); step(1, "glitch");
        step(0, "glitch"); step(0, "glitch");
        for (int i = 0; i < LAT; i++) step(0, "glitch_flush");
        chk("glitch_level", level, 0);
        measure("rise2", 1, LAT);
        measure("fall2", 0, LAT);
        for (int i = 0; i < 3; i++) step(0, "pre_rst");

        // reset mid-check: two agreeing samples reach the FSM, then reset
        for (int i = 0; i < LAT - N + 2; i++) step(1, "midchk");
        assert_reset("midrst");
        for (int i = 0; i < 3; i++) step(1, "midrst_hold");
        release_reset();
        measure("post_rst_rise", 1, LAT);

        // reset while level is high forces it low at once
        assert_reset("hirst");
        step(0, "hirst_hold");
        release_reset();

        // randomized bouncing runs with occasional reset
        for (int r = 0; r < 600; r++) begin
            bit b;
            int len;
            b = 1'($urandom);
            len = $urandom_range(1, 7);
            for (int i = 0; i < len; i++) step(b, "rand");
            if ($urandom_range(0, 99) == 0) begin
                assert_reset("rand_rst");
                step(1'($urandom), "rand_rst_hold");
                release_reset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Front-end conditioning stage for the flip-flop library. Takes a raw, bouncing, possibly asynchronous switch or button input and produces a clean, glitch-free level plus one-cycle edge pulses. Its `level` output drives the `D` input of the downstream D flip-flop stages directly. A change is accepted only after the input holds the new value for a programmable number of consecutive clock cycles.

## Interface
- `STABLE_CYCLES`, 16: consecutive agreeing samples required to accept a change; legal range 2 .. 2^CNT_W − 1.
- `CNT_W`, 5: stability counter width; must satisfy 2^CNT_W > STABLE_CYCLES.

- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset; deasserted when high.
- `btn_in`  input  1  raw bouncing input.
- `level`  output  1  debounced level; feeds downstream `D`.
- `rise_pulse`  output  1  one-cycle pulse when `level` goes 0→1.
- `fall_pulse`  output  1  one-cycle pulse when `level` goes 1→0.

## Operation
- `s` is the sampled input: the synchronizer output with the sync stage compiled in, otherwise `btn_in` directly.
- FSM has four states, all registered: `IDLE_LOW`, `CHECK_HIGH`, `IDLE_HIGH`, `CHECK_LOW`.
- `IDLE_LOW` (`level`=0):
  - `s`=1 → `CHECK_HIGH`, cnt=1.
  - Otherwise stay, cnt=0.
- `CHECK_HIGH`:
  - `s`=0 (bounce) → `IDLE_LOW`, cnt=0, no output change.
  - `s`=1 and cnt<STABLE_CYCLES−1 → cnt+1.
  - `s`=1 and cnt==STABLE_CYCLES−1 → `IDLE_HIGH`, `level`←1, `rise_pulse`←1 for exactly one cycle, cnt=0.
- `IDLE_HIGH` and `CHECK_LOW` mirror the above with polarity inverted, producing `fall_pulse`.
- cnt never exceeds STABLE_CYCLES−1 and never wraps; any disagreeing sample clears it.
- `rise_pulse` and `fall_pulse` are never asserted together and are never asserted on consecutive cycles. This follows because a transition needs at least STABLE_CYCLES ≥ 2 further edges.
- Reset values while `reset`=0: state `IDLE_LOW`, cnt=0, `level`=0, both pulses 0, synchronizer flops 0.
- Reset asserted mid-`CHECK_*` abandons the check. A pending change is never committed.
- After reset release, if `btn_in` is already 1, a normal `IDLE_LOW`→`CHECK_HIGH` sequence follows. `rise_pulse` fires when it completes.

## Timing
- All outputs are registered; there is no combinational path from `btn_in` to any output.
- Define edge E as the first rising edge at which `s` holds the new value. If `s` then stays stable, `level` changes and the pulse asserts at edge E+STABLE_CYCLES−1, i.e. the STABLE_CYCLES-th agreeing sample.
- The pulse deasserts at the next edge.
- Added latency with the sync stage: 2 cycles, measured from `btn_in` to `s`.
- A glitch of fewer than STABLE_CYCLES samples is fully rejected: no change on `level` and no pulse.
- Reset is asynchronous on assertion. Deassertion is expected to be synchronized externally to `clk`.

## Configuration
- `DEBOUNCE_SYNC_EN` defined:
  - A 2-flop synchronizer sits on `btn_in`; `s` is the second flop.
  - Total latency is STABLE_CYCLES+1 edges after the first `btn_in` sample.
  - Required when `btn_in` is asynchronous.
- Not defined:
  - `s` = `btn_in`; the caller guarantees `btn_in` is synchronous to `clk`.
  - Latency is STABLE_CYCLES−1 edges after E.
  - No synchronizer flops exist.

## Structure
- Shared package `debounce_pkg`:
  - 2-bit state encodings `IDLE_LOW`=0, `CHECK_HIGH`=1, `IDLE_HIGH`=2, `CHECK_LOW`=3.
  - Default `STABLE_CYCLES` / `CNT_W` constants.
- Sub-module `sync_2ff` (clk, reset active-low async, `d`, `q`):
  - Instantiated only under `DEBOUNCE_SYNC_EN`.
  - Reusable by other asynchronous-input stages.

## Test plan
Bench uses STABLE_CYCLES=4, macro undefined unless stated.
- Reset held, `btn_in` toggling → `level`=0 and pulses 0 throughout; state `IDLE_LOW`.
- `btn_in` 0→1 held 4 samples → `level`=1 and `rise_pulse`=1 at the 4th edge only; `rise_pulse`=0 at the next edge.
- `btn_in` pattern 1,1,1,0 then 0 → `level` stays 0 and no pulse. Then 4×1 → rise at the 4th of those samples.
- `level`=1, `btn_in`→0 held 4 samples → `fall_pulse` exactly one cycle, `level`=0.
- `reset` asserted after 2 agreeing samples in `CHECK_HIGH` → outputs 0 immediately. After release with `btn_in`=1, rise occurs 4 samples later.
- `DEBOUNCE_SYNC_EN` defined, `btn_in` 0→1 held → `rise_pulse` 2 cycles later than in the unsynchronized case, i.e. at the 6th edge after `btn_in` changes.
